// File: rtl/qmem_word_port.sv
// qmem_word_port
// Responder side of the word-wide table-memory interface. A 16-bit little-endian word is read
// from or written to an internal byte-wide memory as two serial byte accesses (LO, then HI).
// Completion is signalled by a one-cycle ack pulse; out-of-range accesses are rejected with
// ack+err one cycle after acceptance.
//
// Ports:
//   clock    system clock, rising edge
//   rst      asynchronous active-high reset
//   req      access request, sampled only in IDLE
//   wr       1 = write, 0 = read, sampled with req
//   address  byte address of the low byte, sampled with req
//   wr_data  write word, sampled with req
//   rd_data  last completed read word
//   ack      one-cycle completion pulse
//   err      high with ack when the access was rejected
//   busy     high whenever the FSM is not idle
module qmem_word_port #(
   parameter int unsigned MEM_DEPTH  = 2048,
   parameter int unsigned MEM_WIDTH  = 8,
   parameter int unsigned WORD_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  wr,
   input  logic [WORD_WIDTH-1:0] address,
   input  logic [WORD_WIDTH-1:0] wr_data,
   output logic [WORD_WIDTH-1:0] rd_data,
   output logic                  ack,
   output logic                  err,
   output logic                  busy
);

   localparam int unsigned MemAw = $clog2(MEM_DEPTH);
   // Highest legal low-byte address: the high byte must still fit in the memory.
   localparam logic [WORD_WIDTH-1:0] LastAddr = WORD_WIDTH'(MEM_DEPTH - 2);

   typedef enum logic [2:0] {
      StIdle,
      StLo,
      StHi,
      StDone,
      StErr
   } state_e;

   state_e                state_q, state_d;
   logic                  accept;
   logic                  wr_q;
   logic [WORD_WIDTH-1:0] addr_q;
   logic [WORD_WIDTH-1:0] wdata_q;
   logic [WORD_WIDTH-1:0] addr_inc;
   logic [WORD_WIDTH-1:0] rd_data_q;
   logic [MEM_WIDTH-1:0]  lo_q;
   logic [MemAw-1:0]      lo_idx;
   logic [MemAw-1:0]      hi_idx;
   logic                  unused_addr_bits;

   logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];

   assign accept   = (state_q == StIdle) && req;
   assign addr_inc = addr_q + WORD_WIDTH'(1);
   // The range check at acceptance guarantees both indices are in range, so the upper
   // address bits carry no information past that point.
   assign lo_idx   = addr_q[MemAw-1:0];
   assign hi_idx   = addr_inc[MemAw-1:0];
   assign unused_addr_bits = ^{addr_q[WORD_WIDTH-1:MemAw], addr_inc[WORD_WIDTH-1:MemAw]};

   // State register
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = StIdle;
      case (state_q)
         StIdle: begin
            if (req) begin
               state_d = (address > LastAddr) ? StErr : StLo;
            end else begin
               state_d = StIdle;
            end
         end
         StLo:    state_d = StHi;
         StHi:    state_d = StDone;
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the registered state only, so ack/err cannot glitch.
   always_comb begin
      ack  = 1'b0;
      err  = 1'b0;
      busy = 1'b1;
      case (state_q)
         StIdle:  busy = 1'b0;
         StDone:  ack  = 1'b1;
         StErr: begin
            ack = 1'b1;
            err = 1'b1;
         end
         default: ;
      endcase
   end

   // Request latch and read datapath
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         lo_q      <= '0;
         rd_data_q <= '0;
      end else begin
         if (accept) begin
            wr_q    <= wr;
            addr_q  <= address;
            wdata_q <= wr_data;
         end
         if ((state_q == StLo) && !wr_q) begin
            lo_q <= mem[lo_idx];
         end
         // Both halves land together so rd_data never shows a half-updated word.
         if ((state_q == StHi) && !wr_q) begin
            rd_data_q <= {mem[hi_idx], lo_q};
         end
      end
   end

   // Table memory is never reset; an aborted write may leave only the low byte updated.
   always_ff @(posedge clock) begin
      if ((state_q == StLo) && wr_q) begin
         mem[lo_idx] <= wdata_q[MEM_WIDTH-1:0];
      end
      if ((state_q == StHi) && wr_q) begin
         mem[hi_idx] <= wdata_q[WORD_WIDTH-1:MEM_WIDTH];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_qmem_word_port.sv
module tb_qmem_word_port;

   logic        clock = 1'b0;
   logic        rst;
   logic        req;
   logic        wr;
   logic [15:0] address;
   logic [15:0] wr_data;
   logic [15:0] rd_data;
   logic        ack;
   logic        err;
   logic        busy;

   qmem_word_port #(
      .MEM_DEPTH  (2048),
      .MEM_WIDTH  (8),
      .WORD_WIDTH (16)
   ) dut (
      .clock   (clock),
      .rst     (rst),
      .req     (req),
      .wr      (wr),
      .address (address),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .ack     (ack),
      .err     (err),
      .busy    (busy)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic        e;
      logic [15:0] rd;
      int unsigned at;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic e, input logic [15:0] rd);
      exp_t x;
      x.e  = e;
      x.rd = rd;
      x.at = cyc + (e ? 1 : 3);
      sb.push_back(x);
   endtask

   // Waits (bounded) until every expected ack has been seen, then moves to the next negedge.
   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         #1;
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_bad++;
         $display("FAIL ack_timeout: %0d acks outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clock);
   endtask

   // One request pulse; inputs are scrambled right after acceptance to prove they were latched.
   task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic e, input logic [15:0] rd);
      req     = 1'b1;
      wr      = w;
      address = a;
      wr_data = d;
      push_exp(e, rd);
      @(negedge clock);
      req     = 1'b0;
      wr      = ~w;
      address = ~a;
      wr_data = ~d;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_done();
   endtask

   initial begin
      rst     = 1'b1;
      req     = 1'b0;
      wr      = 1'b0;
      address = '0;
      wr_data = '0;

      fork
         forever begin
            @(negedge clock);
            if (ack === 1'b1) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_ack: ack=1 err=%0b rd_data=0x%0h, expected no ack",
                           err, rd_data);
               end else begin
                  exp_t x;
                  x = sb.pop_front();
                  check("ack_err", {31'd0, err}, {31'd0, x.e});
                  check("rd_data", {16'd0, rd_data}, {16'd0, x.rd});
                  check("ack_cycle", cyc, x.at);
               end
            end else if (err !== 1'b0) begin
               check("err_without_ack", {31'd0, err}, 32'd0);
            end
         end
      join_none

      repeat (2) @(negedge clock);
      rst = 1'b0;
      #1;
      check("reset_rd_data", {16'd0, rd_data}, 32'd0);
      check("reset_ack", {31'd0, ack}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);

      // Little-endian write/read plus byte views through odd-address reads
      access(1'b1, 16'h0148, 16'hBEEF, 1'b0, 16'h0000);
      access(1'b0, 16'h0148, 16'h0000, 1'b0, 16'hBEEF);
      access(1'b1, 16'h014A, 16'h0000, 1'b0, 16'hBEEF);
      access(1'b1, 16'h0146, 16'h0000, 1'b0, 16'hBEEF);
      access(1'b0, 16'h0149, 16'h0000, 1'b0, 16'h00BE);
      access(1'b0, 16'h0147, 16'h0000, 1'b0, 16'hEF00);

      // Odd-address read spanning two words
      access(1'b1, 16'h01C8, 16'h1234, 1'b0, 16'hEF00);
      access(1'b1, 16'h01CA, 16'h5678, 1'b0, 16'hEF00);
      access(1'b0, 16'h01C9, 16'h0000, 1'b0, 16'h7812);

      // Range boundary: last legal word, then rejected accesses, then nothing modified
      access(1'b1, 16'h0000, 16'h0102, 1'b0, 16'h7812);
      access(1'b1, 16'h07FE, 16'h3344, 1'b0, 16'h7812);
      access(1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h3344);
      access(1'b0, 16'h07FF, 16'h0000, 1'b1, 16'h3344);
      access(1'b1, 16'hFFFF, 16'h9999, 1'b1, 16'h3344);
      access(1'b1, 16'hFFFE, 16'h9999, 1'b1, 16'h3344);
      access(1'b1, 16'h0800, 16'h9999, 1'b1, 16'h3344);
      access(1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h3344);
      access(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0102);

      // Request pulsed while busy must be ignored
      access(1'b1, 16'h0050, 16'h0000, 1'b0, 16'h0102);
      req     = 1'b1;
      wr      = 1'b1;
      address = 16'h0048;
      wr_data = 16'hCAFE;
      push_exp(1'b0, 16'h0102);
      @(negedge clock);
      check("busy_in_lo", {31'd0, busy}, 32'd1);
      req     = 1'b1;
      wr      = 1'b1;
      address = 16'h0050;
      wr_data = 16'hDEAD;
      @(negedge clock);
      req = 1'b0;
      wait_done();
      access(1'b0, 16'h0050, 16'h0000, 1'b0, 16'h0000);
      access(1'b0, 16'h0048, 16'h0000, 1'b0, 16'hCAFE);

      // Reset in HI of a write: low byte written, high byte old, no ack
      access(1'b1, 16'h0060, 16'h0000, 1'b0, 16'hCAFE);
      req     = 1'b1;
      wr      = 1'b1;
      address = 16'h0060;
      wr_data = 16'hAAAA;
      @(negedge clock);
      req = 1'b0;
      @(negedge clock);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ack", {31'd0, ack}, 32'd0);
      check("abort_rd_data", {16'd0, rd_data}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      rst = 1'b0;
      @(negedge clock);
      access(1'b0, 16'h0060, 16'h0000, 1'b0, 16'h00AA);

      // req held high with alternating write/read: one access every 4 cycles
      req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr      = (k % 2 == 0);
         address = (k < 2) ? 16'h0100 : 16'h0102;
         wr_data = (k < 2) ? 16'h1111 : 16'h2222;
         case (k)
            0:       push_exp(1'b0, 16'h00AA);
            1:       push_exp(1'b0, 16'h1111);
            2:       push_exp(1'b0, 16'h1111);
            default: push_exp(1'b0, 16'h2222);
         endcase
         repeat (4) @(negedge clock);
      end
      req = 1'b0;
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
